// File: rtl/muldiv_ctrl_if.sv
// Handshake bundle between decode/commit/writeback and the mul/div controller.
interface muldiv_ctrl_if;
  logic       issue_valid;
  logic [3:0] mulDiv_op;
  logic [4:0] issue_rd;
  logic       divisor_zero;
  logic       flush;
  logic       wb_ready;
  logic       issue_ready;
  logic       stall;
  logic       dp_start;
  logic       dp_step;
  logic [3:0] dp_op;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       wb_dbz;

  // Pipeline side: offers instructions, flushes, accepts results.
  modport master (
    output issue_valid, mulDiv_op, issue_rd, divisor_zero, flush, wb_ready,
    input  issue_ready, stall, dp_start, dp_step, dp_op, wb_valid, wb_rd, wb_dbz
  );

  // Controller side.
  modport slave (
    input  issue_valid, mulDiv_op, issue_rd, divisor_zero, flush, wb_ready,
    output issue_ready, stall, dp_start, dp_step, dp_op, wb_valid, wb_rd, wb_dbz
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle mul/div sequencing controller: accepts one op at a time,
// drives the iterative datapath for a fixed cycle count, then holds the
// result for writeback. Divide-by-zero skips the datapath entirely.
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 33
) (
  input logic         clk,
  input logic         nrst,
  muldiv_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d;
  logic [4:0] rd_q, rd_d;
  logic       dbz_q, dbz_d;
  logic       first_q, first_d;
  logic       legal_op;
  logic       accept;

  // Decode the eight opcodes the datapath implements.
  always_comb begin
    legal_op = 1'b0;
    case (bus.mulDiv_op)
      4'b0011, 4'b0101, 4'b0111, 4'b0110,
      4'b1001, 4'b1011, 4'b1101, 4'b1111: legal_op = 1'b1;
      default:                            legal_op = 1'b0;
    endcase
  end

  assign accept = bus.issue_valid & bus.issue_ready & legal_op;

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    dbz_d   = dbz_q;
    first_d = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      dbz_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_d = bus.mulDiv_op;
            rd_d = bus.issue_rd;
            if (!bus.mulDiv_op[3]) begin
              state_d = MUL;
              cnt_d   = 6'(MUL_CYCLES - 1);
              first_d = 1'b1;
            end else if (bus.divisor_zero) begin
              state_d = DONE;
              dbz_d   = 1'b1;
            end else begin
              state_d = DIV;
              cnt_d   = 6'(DIV_CYCLES - 1);
              first_d = 1'b1;
            end
          end
        end
        MUL, DIV: begin
          if (cnt_q == '0) state_d = DONE;
          else             cnt_d   = cnt_q - 6'd1;
        end
        DONE: begin
          if (bus.wb_ready) begin
            state_d = IDLE;
            dbz_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and latched operand registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      dbz_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      dbz_q   <= dbz_d;
      first_q <= first_d;
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    bus.issue_ready = (state_q == IDLE) & ~bus.flush;
    bus.stall       = (state_q != IDLE);
    bus.dp_step     = (state_q == MUL) | (state_q == DIV);
    bus.dp_start    = first_q & bus.dp_step;
    bus.wb_valid    = (state_q == DONE) & ~bus.flush;
    bus.dp_op       = op_q;
    bus.wb_rd       = rd_q;
    bus.wb_dbz      = dbz_q;
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed scenarios plus random ops,
// checked against a latency/behaviour model derived from the op rules.
module tb_muldiv_ctrl;
  localparam int unsigned MULC = 3;
  localparam int unsigned DIVC = 33;

  logic clk = 1'b0;
  logic nrst;
  muldiv_ctrl_if bus();

  muldiv_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [3:0]  legal [8];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.issue_valid  = 1'b0;
    bus.mulDiv_op    = 4'b0000;
    bus.issue_rd     = 5'd0;
    bus.divisor_zero = 1'b0;
    bus.flush        = 1'b0;
    bus.wb_ready     = 1'b0;
  endtask

  // Accept-to-first-wb_valid distance in cycles.
  function automatic int unsigned lat(input logic [3:0] op, input logic dz);
    if (op[3] && dz) return 1;
    return 1 + (op[3] ? DIVC : MULC);
  endfunction

  // Issue one op and follow it cycle by cycle. hold = cycles of wb_ready=0
  // in DONE; flush_at = cycle offset from accept to pulse flush (0 = never).
  task automatic run_op(input logic [3:0] op, input logic [4:0] rd, input logic dz,
                        input int unsigned hold, input int unsigned flush_at);
    logic        dbz;
    int unsigned l;
    dbz = op[3] & dz;
    l   = lat(op, dz);
    bus.issue_valid  = 1'b1;
    bus.mulDiv_op    = op;
    bus.issue_rd     = rd;
    bus.divisor_zero = dz;
    bus.flush        = 1'b0;
    bus.wb_ready     = 1'($urandom);
    #1;
    chk("accept_ready", 8'(bus.issue_ready), 8'd1);
    tick();
    for (int unsigned k = 1; k <= l + hold; k++) begin
      bus.issue_valid  = 1'($urandom);
      bus.mulDiv_op    = legal[$urandom_range(0, 7)];
      bus.issue_rd     = 5'($urandom);
      bus.divisor_zero = 1'($urandom);
      bus.wb_ready     = (k < l) ? 1'($urandom) : (k >= l + hold);
      if (k == flush_at) begin
        bus.flush = 1'b1;
        #1;
        chk("flush_ready", 8'(bus.issue_ready), 8'd0);
        chk("flush_wbv",   8'(bus.wb_valid),    8'd0);
        tick();
        quiet();
        #1;
        chk("post_flush_stall", 8'(bus.stall),       8'd0);
        chk("post_flush_dbz",   8'(bus.wb_dbz),      8'd0);
        chk("post_flush_ready", 8'(bus.issue_ready), 8'd1);
        chk("post_flush_start", 8'(bus.dp_start),    8'd0);
        return;
      end
      #1;
      chk("stall",  8'(bus.stall),       8'd1);
      chk("ready",  8'(bus.issue_ready), 8'd0);
      chk("dp_op",  8'(bus.dp_op),       8'(op));
      chk("wb_rd",  8'(bus.wb_rd),       8'(rd));
      if (k < l) begin
        chk("dp_start", 8'(bus.dp_start), 8'(k == 1));
        chk("dp_step",  8'(bus.dp_step),  8'd1);
        chk("wbv_exec", 8'(bus.wb_valid), 8'd0);
      end else begin
        chk("wbv_done",   8'(bus.wb_valid), 8'd1);
        chk("wb_dbz",     8'(bus.wb_dbz),   8'(dbz));
        chk("start_done", 8'(bus.dp_start), 8'd0);
        chk("step_done",  8'(bus.dp_step),  8'd0);
      end
      tick();
    end
    quiet();
    #1;
    chk("ret_stall", 8'(bus.stall),       8'd0);
    chk("ret_wbv",   8'(bus.wb_valid),    8'd0);
    chk("ret_dbz",   8'(bus.wb_dbz),      8'd0);
    chk("ret_ready", 8'(bus.issue_ready), 8'd1);
  endtask

  initial begin
    logic [3:0]  op;
    logic        dz;
    int unsigned h;
    int unsigned fa;
    legal = '{4'b0011, 4'b0101, 4'b0111, 4'b0110, 4'b1001, 4'b1011, 4'b1101, 4'b1111};
    quiet();
    nrst = 1'b0;
    #3;
    chk("rst_stall", 8'(bus.stall),       8'd0);
    chk("rst_wbv",   8'(bus.wb_valid),    8'd0);
    chk("rst_dp_op", 8'(bus.dp_op),       8'd0);
    chk("rst_wb_rd", 8'(bus.wb_rd),       8'd0);
    chk("rst_ready", 8'(bus.issue_ready), 8'd1);
    #9 nrst = 1'b1;
    tick();

    // MUL rd=5, immediate writeback.
    run_op(4'b0011, 5'd5, 1'b0, 0, 0);
    // DIVU, nonzero divisor.
    run_op(4'b1011, 5'd9, 1'b0, 0, 0);
    // REM by zero goes straight to DONE.
    run_op(4'b1101, 5'd17, 1'b1, 0, 0);
    // DIV flushed at T+10, then MUL accepted at T+11.
    run_op(4'b1001, 5'd3, 1'b0, 0, 10);
    run_op(4'b0011, 5'd4, 1'b0, 0, 0);
    // Writeback back-pressure for 4 cycles.
    run_op(4'b0110, 5'd30, 1'b0, 4, 0);
    // Flush while a divide-by-zero result waits in DONE.
    run_op(4'b1111, 5'd12, 1'b1, 3, 2);

    // Illegal codes are ignored.
    for (int unsigned c = 0; c < 16; c++) begin
      if (c inside {3, 5, 6, 7, 9, 11, 13, 15}) continue;
      bus.issue_valid = 1'b1;
      bus.mulDiv_op   = 4'(c);
      tick();
      quiet();
      #1;
      chk("illegal_ignored", 8'(bus.stall), 8'd0);
    end

    // Flush in IDLE blocks accept.
    bus.issue_valid = 1'b1;
    bus.mulDiv_op   = 4'b0101;
    bus.flush       = 1'b1;
    #1;
    chk("idle_flush_ready", 8'(bus.issue_ready), 8'd0);
    tick();
    quiet();
    #1;
    chk("idle_flush_stall", 8'(bus.stall), 8'd0);

    // Reset during DIV at T+5.
    bus.issue_valid = 1'b1;
    bus.mulDiv_op   = 4'b1001;
    bus.issue_rd    = 5'd21;
    tick();
    quiet();
    repeat (4) tick();
    chk("pre_rst_step", 8'(bus.dp_step), 8'd1);
    nrst = 1'b0;
    #1;
    chk("mid_rst_stall", 8'(bus.stall),       8'd0);
    chk("mid_rst_step",  8'(bus.dp_step),     8'd0);
    chk("mid_rst_start", 8'(bus.dp_start),    8'd0);
    chk("mid_rst_wbv",   8'(bus.wb_valid),    8'd0);
    chk("mid_rst_dp_op", 8'(bus.dp_op),       8'd0);
    chk("mid_rst_wb_rd", 8'(bus.wb_rd),       8'd0);
    chk("mid_rst_dbz",   8'(bus.wb_dbz),      8'd0);
    chk("mid_rst_ready", 8'(bus.issue_ready), 8'd1);
    tick();
    nrst = 1'b1;
    for (int unsigned i = 0; i < 40; i++) begin
      tick();
      chk("post_rst_wbv",   8'(bus.wb_valid),    8'd0);
      chk("post_rst_ready", 8'(bus.issue_ready), 8'd1);
    end

    // Random ops.
    for (int unsigned i = 0; i < 30; i++) begin
      op = legal[$urandom_range(0, 7)];
      dz = 1'($urandom);
      h  = $urandom_range(0, 4);
      fa = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lat(op, dz) + h) : 0;
      run_op(op, 5'($urandom), dz, h, fa);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 3: number of execute cycles for MUL/MULH/MULHSU/MULHU (legal range 1..63).
REQ-002 SHALL have parameter DIV_CYCLES, default 33: number of execute cycles for DIV/DIVU/REM/REMU (legal range 1..63).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port nrst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port issue_valid  in  1  decode stage offers an instruction.
REQ-006 SHALL have port mulDiv_op  in  4  decoded mul/div opcode (0000 no_op; 0011 MUL, 0101 MULH, 0111 MULHU, 0110 MULHSU, 1001 DIV, 1011 DIVU, 1101 REM, 1111 REMU).
REQ-007 SHALL have port issue_rd  in  5  destination register of the offered instruction.
REQ-008 SHALL have port divisor_zero  in  1  rs2 == 0, valid in the issue cycle.
REQ-009 SHALL have port flush  in  1  kill from commit (exception_pending).
REQ-010 SHALL have port wb_ready  in  1  writeback accepts the result.
REQ-011 SHALL have port issue_ready  out  1  controller can accept an operation.
REQ-012 SHALL have port stall  out  1  hold the front end.
REQ-013 SHALL have port dp_start  out  1  one-cycle pulse to load datapath operands.
REQ-014 SHALL have port dp_step  out  1  datapath iteration enable.
REQ-015 SHALL have port dp_op  out  4  latched opcode driven to the datapath.
REQ-016 SHALL have port wb_valid  out  1  result available.
REQ-017 SHALL have port wb_rd  out  5  latched destination register.
REQ-018 SHALL have port wb_dbz  out  1  result is the divide-by-zero value (DIV/DIVU: all ones, REM/REMU: dividend).

Function
REQ-019 SHALL implement states IDLE, MUL, DIV, DONE; issue_ready = (state==IDLE) & ~flush; stall = (state!=IDLE).
REQ-020 SHALL accept an operation when issue_valid & issue_ready & mulDiv_op is one of the eight legal codes; any other code (including 0000) is ignored and the state stays IDLE.
REQ-021 SHALL on accept latch mulDiv_op into dp_op and issue_rd into wb_rd; both held stable until the state returns to IDLE.
REQ-022 SHALL on accept of a mul op (mulDiv_op[3]=0) enter MUL with the down-counter loaded to MUL_CYCLES-1.
REQ-023 SHALL on accept of a div/rem op with divisor_zero=0 enter DIV with the counter loaded to DIV_CYCLES-1.
REQ-024 SHALL on accept of a div/rem op with divisor_zero=1 enter DONE directly with wb_dbz=1; dp_start and dp_step are never asserted for that op.
REQ-025 SHALL assert dp_start in the first cycle of MUL or DIV only.
REQ-026 SHALL assert dp_step in every MUL/DIV cycle, decrement the counter each cycle, and move to DONE in the cycle after the counter is 0; MUL lasts exactly MUL_CYCLES cycles and DIV lasts exactly DIV_CYCLES cycles.
REQ-027 SHALL set wb_valid = (state==DONE) & ~flush; on wb_valid & wb_ready, return to IDLE next cycle and clear wb_dbz; DONE holds indefinitely while wb_ready=0.
REQ-028 SHALL latency: accept at cycle T gives first wb_valid at T+1+MUL_CYCLES (mul), T+1+DIV_CYCLES (div), T+1 (divide-by-zero).
REQ-029 SHALL not accept a new operation in the same cycle as a writeback handshake (issue_ready=0 in DONE).
REQ-030 SHALL give flush top priority: any state goes to IDLE next cycle, the counter clears, wb_dbz clears, and no dp_start is issued; flush in IDLE blocks accept.
REQ-031 SHALL use a counter width of 6 bits; a counter value of 0 in MUL/DIV never wraps.

Reset
REQ-032 SHALL, while nrst=0, asynchronously force state IDLE, counter 0, dp_op 0, wb_rd 0, wb_dbz 0, dp_start 0, dp_step 0, wb_valid 0, stall 0; issue_ready = ~flush.
REQ-033 SHALL, when reset asserts mid-operation, discard that operation with no writeback after release.

Verification
REQ-034 SHALL cover: MUL (0011), rd=5, wb_ready=1, accepted at T -> dp_start@T+1, dp_step@T+1..T+3, wb_valid with wb_rd=5 @T+4, IDLE @T+5.
REQ-035 SHALL cover: DIVU (1011), divisor_zero=0 -> 33 dp_step cycles, wb_valid@T+34, wb_dbz=0.
REQ-036 SHALL cover: REM (1101), divisor_zero=1 -> wb_valid@T+1 with wb_dbz=1; dp_start and dp_step stay 0.
REQ-037 SHALL cover: DIV with flush pulsed at T+10 -> IDLE@T+11, no wb_valid; next MUL accepted at T+11.
REQ-038 SHALL cover: wb_ready=0 for 4 cycles in DONE -> wb_valid and wb_rd held stable; stall=1; issue_valid with a legal op not accepted.
REQ-039 SHALL cover: nrst asserted during DIV at T+5 -> all outputs at reset values immediately; issue_ready=1 after release.
